// File: rtl/trigger_energy_detector.sv
// trigger_energy_detector: sliding-window sum-of-squares energy with threshold trigger and holdoff
module trigger_energy_detector #(
    parameter int NSAMP    = 8,
    parameter int NBITS    = 12,
    parameter int WINDOW   = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                   aclk,
    input  logic                   reset_i,
    input  logic [NSAMP*NBITS-1:0] dat_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic [31:0]            threshold_i,
    input  logic [15:0]            holdoff_i,
    output logic [31:0]            energy_o,
    output logic                   trig_o,
    output logic [CNT_BITS-1:0]    trig_count_o
);
    localparam int SQB = 2*NBITS;
    localparam int CSB = SQB + $clog2(NSAMP);
    localparam int WSB = CSB + $clog2(WINDOW);
    localparam logic [1:0] DISABLED = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] HOLDOFF  = 2'd2;

    logic [SQB-1:0] sq [NSAMP];
    logic [SQB-1:0] sq_n [NSAMP];
    logic [CSB-1:0] csum, csum_n;
    logic [CSB-1:0] hist [WINDOW];
    logic [WSB-1:0] wsum;
    logic [1:0]     state, state_n;
    logic [15:0]    hcnt, hcnt_n;
    logic           fire;

    always_comb begin
        for (int k = 0; k < NSAMP; k++)
            sq_n[k] = SQB'($signed(dat_i[NBITS*k +: NBITS]) * $signed(dat_i[NBITS*k +: NBITS]));
        csum_n = '0;
        for (int k = 0; k < NSAMP; k++)
            csum_n = csum_n + CSB'(sq[k]);
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i || clear_i) begin
            sq   <= '{default: '0};
            csum <= '0;
            hist <= '{default: '0};
            wsum <= '0;
        end else begin
            sq      <= sq_n;
            csum    <= csum;
            csum    <= csum_n;
            hist[0] <= csum;
            for (int w = 1; w < WINDOW; w++)
                hist[w] <= hist[w-1];
            wsum <= wsum + WSB'(csum) - WSB'(hist[WINDOW-1]);
        end
    end

    assign energy_o = 32'(wsum);

    // clear_i suppresses a trigger even when the compare would pass on the same edge
    always_comb begin
        fire    = !clear_i && enable_i && state == IDLE && energy_o > threshold_i;
        hcnt_n  = clear_i ? '0 : fire ? holdoff_i : state == HOLDOFF ? hcnt - 16'd1 : hcnt;
        state_n = clear_i ? IDLE :
                  !enable_i ? DISABLED :
                  state == DISABLED ? IDLE :
                  state == IDLE ? ((fire && holdoff_i != '0) ? HOLDOFF : IDLE) :
                  state == HOLDOFF ? (hcnt <= 16'd1 ? IDLE : HOLDOFF) : IDLE;
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            hcnt         <= '0;
            trig_o       <= 1'b0;
            trig_count_o <= '0;
        end else begin
            state  <= state_n;
            hcnt   <= hcnt_n;
            trig_o <= fire;
            if (fire && !(&trig_count_o))
                trig_count_o <= trig_count_o + CNT_BITS'(1);
        end
    end
endmodule
